// File: rtl/alu_pkg.sv
// Shared types and constants for the accumulate stage.
package alu_pkg;

  localparam int ACC_WIDTH_DEFAULT = 16;
  localparam int BUS_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } accum_state_t;

endpackage

// File: rtl/sfixed_sat.sv
// Signed saturating narrow: clamps a two's-complement value of IN_W bits
// into OUT_W bits and flags when the clamp was applied.
module sfixed_sat #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o,
  output logic             sat_o
);

  // The value fits when all bits from the MSB down to the output sign bit agree.
  localparam int HW = IN_W - OUT_W + 1;

  logic [HW-1:0] head;
  logic          fits;

  // Pick pass-through, most negative or most positive output.
  always_comb begin
    head  = din_i[IN_W-1:OUT_W-1];
    fits  = (head == '0) || (head == '1);
    sat_o = ~fits;
    if (fits) begin
      dout_o = din_i[OUT_W-1:0];
    end else if (din_i[IN_W-1]) begin
      dout_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/alu_accum_stage.sv
// Accumulate stage: sums len pairs of signed products into a wide saturating
// accumulator, then presents the bus-width saturated sum until it is taken.
//
// Handshakes: a pair transfers on a cycle where in_valid & in_ready are both
// high at posedge clk; the result transfers on a cycle where out_valid &
// out_ready are both high. Valid never waits on ready, result and out_valid
// stay stable while out_valid is high and out_ready is low, and result is a
// register so nothing on the input or ready side reaches it combinationally.
module alu_accum_stage
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT,
  parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] mult_a,
  input  logic [BUS_WIDTH-1:0] mult_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 busy,
  output logic                 ovf,
  output accum_state_t         state_o
);

  // Two extra bits hold acc + a + b without wrapping before the clamp.
  localparam int SUM_W = ACC_WIDTH + 2;

  accum_state_t         state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [3:0]           count_q, count_d;
  logic [BUS_WIDTH-1:0] result_q, result_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_q, ovf_d;

  logic [SUM_W-1:0]     sum_wide;
  logic [ACC_WIDTH-1:0] acc_sat;
  logic                 acc_clamp;
  logic [BUS_WIDTH-1:0] bus_sat;
  logic                 bus_clamp;
  logic                 accept;

  // Sign-extend every operand to the wide sum width before adding.
  always_comb begin
    sum_wide = {{2{acc_q[ACC_WIDTH-1]}}, acc_q}
             + {{(SUM_W-BUS_WIDTH){mult_a[BUS_WIDTH-1]}}, mult_a}
             + {{(SUM_W-BUS_WIDTH){mult_b[BUS_WIDTH-1]}}, mult_b};
  end

  sfixed_sat #(
    .IN_W  (SUM_W),
    .OUT_W (ACC_WIDTH)
  ) u_sat_acc (
    .din_i  (sum_wide),
    .dout_o (acc_sat),
    .sat_o  (acc_clamp)
  );

  // The bus clamp sees the freshly saturated accumulator value.
  sfixed_sat #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (BUS_WIDTH)
  ) u_sat_bus (
    .din_i  (acc_sat),
    .dout_o (bus_sat),
    .sat_o  (bus_clamp)
  );

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == ACCUM) || (state_q == HOLD);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign state_o   = state_q;

  // Next-state and datapath update for the IDLE / ACCUM / HOLD sequence.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          count_d = (len == 4'd0) ? 4'd1 : len;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_sat;
          count_d = count_q - 4'd1;
          if (acc_clamp) ovf_d = 1'b1;
          if (count_q <= 4'd1) begin
            state_d     = HOLD;
            result_d    = bus_sat;
            out_valid_d = 1'b1;
            if (bus_clamp) ovf_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: doc/alu_accum_stage.md
ALU_ACCUM_STAGE -- requirements
Module: alu_accum_stage

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, width of product inputs and result.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, width of internal signed accumulator.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  begin new accumulation; honoured only in IDLE.
REQ-006 SHALL have port len  input  4  number of product pairs to accumulate, sampled with start.
REQ-007 SHALL have port in_valid  input  1  mult_a/mult_b hold a valid pair.
REQ-008 SHALL have port in_ready  output  1  stage accepts a pair this cycle.
REQ-009 SHALL have port mult_a, mult_b  input  BUS_WIDTH each  signed integer products from the multiply stage.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  BUS_WIDTH  signed saturated sum.
REQ-013 SHALL have port busy  output  1  high in ACCUM or HOLD.
REQ-014 SHALL have port ovf  output  1  sticky saturation flag for current job.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-016 IDLE: start=1 -> ACCUM next cycle; count <= len (len=0 treated as 1); acc <= 0; ovf <= 0.
REQ-017 ACCUM: in_ready=1; accept = in_valid & in_ready; other states in_ready=0.
REQ-018 On accept: acc <= sat_ACC(acc + sext(mult_a) + sext(mult_b)); count decrements by 1.
REQ-019 No accept (in_valid=0): acc, count unchanged; gaps of any length SHALL NOT affect result.
REQ-020 Accept with count=1: -> HOLD next cycle; result <= sat_BUS(new acc); out_valid <= 1 (latency 1 cycle after last accept).
REQ-021 HOLD: result and out_valid stable until out_valid & out_ready; then IDLE next cycle, out_valid <= 0.
REQ-022 start outside IDLE SHALL be ignored, including in HOLD on the cycle of the output handshake.
REQ-023 sat_ACC clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; sat_BUS clamps to [-2^(BUS_WIDTH-1), 2^(BUS_WIDTH-1)-1].
REQ-024 ovf SHALL set when either clamp activates and hold until next honoured start or reset.
REQ-025 result SHALL keep last value in IDLE after handshake.

Reset
REQ-026 rst_n=0 at posedge SHALL force next cycle: state IDLE, acc 0, count 0, result 0, out_valid 0, in_ready 0, busy 0, ovf 0.
REQ-027 Reset in ACCUM or HOLD SHALL abandon the job; no partial result emitted.

Structure
REQ-028 Package alu_pkg SHALL hold accum_state_t enum (IDLE, ACCUM, HOLD) and ACC_WIDTH default constant.
REQ-029 Saturating narrow SHALL be a sub-module sfixed_sat (params IN_W, OUT_W), instantiated for sat_ACC and sat_BUS.
REQ-030 No combinational path from in_valid or out_ready to result.

Verification
REQ-031 len=3, pairs (10,5),(20,-3),(1,1) back-to-back -> out_valid 1 cycle after third accept, result 34, ovf 0.
REQ-032 len=2, pairs (127,127),(127,127) -> acc 508, result 127, ovf 1.
REQ-033 len=2, (-100,-50) then in_valid low 3 cycles then (-20,0) -> result -128, ovf 1; count holds during gap.
REQ-034 result 34 in HOLD, out_ready low 5 cycles with start pulsed -> result/out_valid stable, start ignored; out_ready high -> IDLE next cycle.
REQ-035 rst_n low after 1 of 3 accepts -> all outputs 0 next cycle; then start len=1, pair (-5,-6) -> result -11.
REQ-036 start with len=0, pair (3,4) -> one pair accepted, result 7.
